// File: rtl/seq_timer_pkg.sv
// Shared definitions for the serial-programmed delay timer.
//   state_t                 : controller state encoding (IDLE..DONE)
//   CYCLES_PER_UNIT_DEFAULT : default clock cycles per delay unit
package seq_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S11   = 3'd2,
    ST_S110  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_COUNT = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int unsigned CYCLES_PER_UNIT_DEFAULT = 1000;

endpackage

// File: rtl/seq_timer_unit_cnt.sv
// Unit prescaler plus delay down-counter for the sequence timer.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   load        : load remaining from load_value and restart the unit counter
//   load_value  : delay value captured on load
//   enable      : advance the unit counter this cycle
//   unit_tick   : high in the enabled cycle where the unit counter is at 0
//   remaining   : delay units still to elapse (saturates at 0)
module seq_timer_unit_cnt
  import seq_timer_pkg::*;
#(
  parameter int unsigned CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic       unit_tick,
  output logic [3:0] remaining
);

  localparam int unsigned   UW     = $clog2(CYCLES_PER_UNIT);
  localparam logic [UW-1:0] RELOAD = UW'(CYCLES_PER_UNIT - 1);

  logic [UW-1:0] unit_q, unit_d;
  logic [3:0]    rem_q,  rem_d;

  assign unit_tick = enable && (unit_q == '0);
  assign remaining = rem_q;

  always_comb begin
    unit_d = unit_q;
    rem_d  = rem_q;
    if (load) begin
      unit_d = RELOAD;
      rem_d  = load_value;
    end else if (enable) begin
      if (unit_q == '0) begin
        unit_d = RELOAD;
        // Hold at zero; the controller leaves COUNT on this same tick.
        if (rem_q != '0) begin
          rem_d = rem_q - 4'd1;
        end
      end else begin
        unit_d = unit_q - UW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      unit_q <= RELOAD;
      rem_q  <= '0;
    end else begin
      unit_q <= unit_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/seq_timer_ctrl.sv
// Serial-programmed delay timer. Searches the data stream for 1101,
// shifts in a 4-bit delay (MSB first), counts (delay+1) units of
// CYCLES_PER_UNIT clocks, then holds done until acknowledged.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   data        : serial input (pattern then delay bits)
//   ack         : host acknowledge, only honoured in DONE
//   count       : remaining delay units while counting, else 0
//   counting    : high in every COUNT cycle
//   done        : high in every DONE cycle
module seq_timer_ctrl
  import seq_timer_pkg::*;
#(
  parameter int unsigned CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       data,
  input  logic       ack,
  output logic [3:0] count,
  output logic       counting,
  output logic       done
);

  state_t     state_q, state_d;
  logic [3:0] delay_q, delay_d;
  logic [1:0] bit_q,   bit_d;

  logic       cnt_load;
  logic       cnt_tick;
  logic [3:0] cnt_remaining;

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    bit_d    = '0;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = data ? ST_S1  : ST_IDLE;
      ST_S1:    state_d = data ? ST_S11 : ST_IDLE;
      // A run of 1s keeps the last two as a valid "11" prefix.
      ST_S11:   state_d = data ? ST_S11 : ST_S110;
      ST_S110:  state_d = data ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: begin
        delay_d = {delay_q[2:0], data};
        bit_d   = bit_q + 2'd1;
        if (bit_q == 2'd3) begin
          state_d  = ST_COUNT;
          cnt_load = 1'b1;
        end
      end
      ST_COUNT: begin
        if (cnt_tick && (cnt_remaining == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      bit_q   <= bit_d;
    end
  end

  // Loaded with the fully shifted delay (including the bit sampled this
  // cycle) on the SHIFT->COUNT transition.
  seq_timer_unit_cnt #(
    .CYCLES_PER_UNIT(CYCLES_PER_UNIT)
  ) u_unit_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .load      (cnt_load),
    .load_value(delay_d),
    .enable    (state_q == ST_COUNT),
    .unit_tick (cnt_tick),
    .remaining (cnt_remaining)
  );

  assign counting = (state_q == ST_COUNT);
  assign done     = (state_q == ST_DONE);
  assign count    = counting ? cnt_remaining : '0;

endmodule

// File: tb/tb_seq_timer_ctrl.sv
`timescale 1ns/1ps
module tb_seq_timer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: CYCLES_PER_UNIT=1000, 1: =4, 2: =2
  logic       resetn_v   [3];
  logic       data_v     [3];
  logic       ack_v      [3];
  logic [3:0] count_v    [3];
  logic       counting_v [3];
  logic       done_v     [3];

  seq_timer_ctrl #(.CYCLES_PER_UNIT(1000)) u_dut_1000 (
    .clk(clk), .resetn(resetn_v[0]), .data(data_v[0]), .ack(ack_v[0]),
    .count(count_v[0]), .counting(counting_v[0]), .done(done_v[0]));

  seq_timer_ctrl #(.CYCLES_PER_UNIT(4)) u_dut_4 (
    .clk(clk), .resetn(resetn_v[1]), .data(data_v[1]), .ack(ack_v[1]),
    .count(count_v[1]), .counting(counting_v[1]), .done(done_v[1]));

  seq_timer_ctrl #(.CYCLES_PER_UNIT(2)) u_dut_2 (
    .clk(clk), .resetn(resetn_v[2]), .data(data_v[2]), .ack(ack_v[2]),
    .count(count_v[2]), .counting(counting_v[2]), .done(done_v[2]));

  typedef struct {
    int val;
    int len;
  } seg_t;

  typedef struct {
    logic [15:0] bits;
    int          n;
    bit          trig;
    logic [3:0]  dly;
  } vec_t;

  seg_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Expected count segments: each value delay..0 held for cpu cycles.
  task automatic expect_run(input logic [3:0] dly, input int cpu);
    exp_q.delete();
    for (int v = int'(dly); v >= 0; v--) begin
      exp_q.push_back('{val: v, len: cpu});
    end
  endtask

  task automatic drive_bits(input int idx, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      data_v[idx] = bits[n-1-i];
      @(negedge clk);
    end
    data_v[idx] = 1'b0;
  endtask

  task automatic pop_seg(input string tag, input logic [3:0] val, input int len);
    seg_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_extra_seg: got count=%0d for %0d cycles want no segment", tag, val, len);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_seg_val"}, int'(val), e.val);
      check({tag, "_seg_len"}, len, e.len);
    end
  endtask

  task automatic measure(input int idx, input string tag, input int exp_total);
    int         lat   = 0;
    int         total = 0;
    int         len   = 0;
    logic [3:0] cur;
    while (!counting_v[idx] && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 0);
    if (counting_v[idx]) begin
      cur = count_v[idx];
      while (counting_v[idx] && total < 20000) begin
        if (count_v[idx] != cur) begin
          pop_seg(tag, cur, len);
          cur = count_v[idx];
          len = 0;
        end
        len++;
        total++;
        @(negedge clk);
      end
      pop_seg(tag, cur, len);
    end
    check({tag, "_leftover_segs"}, exp_q.size(), 0);
    check({tag, "_count_cycles"}, total, exp_total);
    check({tag, "_done"}, int'(done_v[idx]), 1);
    check({tag, "_count_in_done"}, int'(count_v[idx]), 0);
  endtask

  task automatic do_ack(input int idx, input string tag);
    ack_v[idx] = 1'b1;
    @(negedge clk);
    ack_v[idx] = 1'b0;
    check({tag, "_done_cleared"}, int'(done_v[idx]), 0);
    check({tag, "_counting_after_ack"}, int'(counting_v[idx]), 0);
  endtask

  task automatic no_trigger(input int idx, input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (counting_v[idx] || done_v[idx]) seen++;
      @(negedge clk);
    end
    check({tag, "_no_trigger"}, seen, 0);
  endtask

  task automatic check_quiet(input int idx, input string tag);
    check({tag, "_count"},    int'(count_v[idx]),    0);
    check({tag, "_counting"}, int'(counting_v[idx]), 0);
    check({tag, "_done"},     int'(done_v[idx]),     0);
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] junk;
    int          held;
    int          k;

    vecs[0] = '{bits: 16'b1101_0011,      n: 8,  trig: 1'b1, dly: 4'd3};
    vecs[1] = '{bits: 16'b1_1101_0011,    n: 9,  trig: 1'b1, dly: 4'd3};
    vecs[2] = '{bits: 16'b1100_1101_0010, n: 12, trig: 1'b1, dly: 4'd2};
    vecs[3] = '{bits: 16'b10_1101_0001,   n: 10, trig: 1'b1, dly: 4'd1};
    vecs[4] = '{bits: 16'b1010_1100,      n: 8,  trig: 1'b0, dly: 4'd0};
    vecs[5] = '{bits: 16'b1101_1111,      n: 8,  trig: 1'b1, dly: 4'd15};
    vecs[6] = '{bits: 16'b0110_0100,      n: 8,  trig: 1'b0, dly: 4'd0};

    for (int i = 0; i < 3; i++) begin
      resetn_v[i] = 1'b0;
      data_v[i]   = 1'b0;
      ack_v[i]    = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_quiet(i, $sformatf("reset%0d", i));
    for (int i = 0; i < 3; i++) resetn_v[i] = 1'b1;

    // Delay 0 and delay 5 at the default unit length
    expect_run(4'd0, 1000);
    drive_bits(0, 16'b1101_0000, 8);
    measure(0, "d0_cpu1000", 1000);
    do_ack(0, "d0_cpu1000");

    expect_run(4'd5, 1000);
    drive_bits(0, 16'b1101_0101, 8);
    measure(0, "d5_cpu1000", 6000);
    do_ack(0, "d5_cpu1000");

    // Table of pattern-search vectors on the 4-cycle unit instance
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].trig) begin
        expect_run(vecs[i].dly, 4);
        drive_bits(1, vecs[i].bits, vecs[i].n);
        measure(1, $sformatf("vec%0d", i), (int'(vecs[i].dly) + 1) * 4);
        do_ack(1, $sformatf("vec%0d", i));
      end else begin
        drive_bits(1, vecs[i].bits, vecs[i].n);
        no_trigger(1, $sformatf("vec%0d", i), 12);
      end
    end

    // DONE holds without ack, ignores data, ack-cycle data is discarded
    expect_run(4'd0, 4);
    drive_bits(1, 16'b1101_0000, 8);
    measure(1, "hold_run", 4);
    junk = 16'b1101_1101_1101_1101;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[1]) held++;
      data_v[1] = junk[15-i];
      @(negedge clk);
    end
    check("hold_done_cycles", held, 10);
    check("hold_done_still", int'(done_v[1]), 1);
    data_v[1] = 1'b1;
    ack_v[1]  = 1'b1;
    @(negedge clk);
    ack_v[1]  = 1'b0;
    data_v[1] = 1'b0;
    check_quiet(1, "hold_after_ack");
    expect_run(4'd1, 4);
    drive_bits(1, 16'b10_1101_0001, 10);
    measure(1, "hold_rearm", 8);
    do_ack(1, "hold_rearm");

    // Reset mid-COUNT at count=2, then require a fresh pattern
    drive_bits(1, 16'b1101_0100, 8);
    k = 0;
    while (!(counting_v[1] && count_v[1] == 4'd2) && k < 100) begin
      k++;
      @(negedge clk);
    end
    check("midcount_reached_2", int'(count_v[1]), 2);
    resetn_v[1] = 1'b0;
    @(negedge clk);
    resetn_v[1] = 1'b1;
    check_quiet(1, "midcount_reset");
    drive_bits(1, 16'b0011, 4);
    no_trigger(1, "midcount_no_restart", 16);
    expect_run(4'd1, 4);
    drive_bits(1, 16'b1101_0001, 8);
    measure(1, "midcount_restart", 8);
    do_ack(1, "midcount_restart");

    // Reset mid-SHIFT discards the partial delay
    drive_bits(1, 16'b11_0101, 6);
    resetn_v[1] = 1'b0;
    @(negedge clk);
    resetn_v[1] = 1'b1;
    check_quiet(1, "midshift_reset");
    drive_bits(1, 16'b01, 2);
    no_trigger(1, "midshift", 16);

    // Max delay with the shortest unit, then reset while in DONE
    expect_run(4'd15, 2);
    drive_bits(2, 16'b1101_1111, 8);
    measure(2, "d15_cpu2", 32);
    resetn_v[2] = 1'b0;
    @(negedge clk);
    resetn_v[2] = 1'b1;
    check_quiet(2, "done_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
